// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetches and load/store requests onto a
// byte-wide RAM with a one-cycle read latency. One request is in flight at
// a time. Loads/stores take priority over fetches. IO stores stall while
// the UART FIFO is full.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mc_en,
  input  logic        mc_wr,
  input  logic [31:0] mc_addr,
  input  logic [2:0]  mc_len,
  input  logic [31:0] mc_w_data,
  output logic        mc_done,
  output logic [31:0] mc_r_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;      // bytes captured (read) or written (store)
  logic        pend_reg, pend_next;    // a read byte for cnt_reg arrives on mem_din this cycle
  logic [31:0] addr_reg, addr_next;
  logic [2:0]  len_reg, len_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] buf_reg, buf_next;      // read assembly buffer
  logic [31:0] if_data_reg, if_data_next;
  logic [31:0] mc_r_data_reg, mc_r_data_next;

  logic        is_io;
  logic [3:0]  issue_idx;              // byte index presented on mem_a this cycle

  assign is_io     = (addr_reg[17:16] == 2'b11);
  assign issue_idx = {1'b0, cnt_reg} + {3'b000, pend_reg};
  assign if_data   = if_data_reg;
  assign mc_r_data = mc_r_data_reg;

  // Next-state, datapath and memory-side outputs
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pend_next      = pend_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    wdata_next     = wdata_reg;
    buf_next       = buf_reg;
    if_data_next   = if_data_reg;
    mc_r_data_next = mc_r_data_reg;
    if_done        = 1'b0;
    mc_done        = 1'b0;
    mem_wr         = 1'b0;
    mem_a          = addr_reg + {28'd0, issue_idx};
    mem_dout       = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];

    if (!rdy) begin
      // Freeze everything; the byte in flight is dropped and re-fetched
      // once rdy returns, because mem_a now points back at cnt_reg.
      pend_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mc_en && mc_wr) begin
            // Stores are accepted even during rollback: they are committed.
            state_next = STORE;
            addr_next  = mc_addr;
            len_next   = mc_len;
            wdata_next = mc_w_data;
            cnt_next   = 3'd0;
            pend_next  = 1'b0;
          end else if (!rollback && mc_en) begin
            state_next = LOAD;
            addr_next  = mc_addr;
            len_next   = mc_len;
            cnt_next   = 3'd0;
            pend_next  = 1'b0;
            buf_next   = 32'd0;
          end else if (!rollback && if_en) begin
            state_next = IFETCH;
            addr_next  = if_addr;
            len_next   = 3'd4;
            cnt_next   = 3'd0;
            pend_next  = 1'b0;
            buf_next   = 32'd0;
          end
        end

        IFETCH, LOAD: begin
          if (cnt_reg == len_reg) begin
            // Done cycle: data already sits in the output register.
            if (state_reg == IFETCH) if_done = 1'b1;
            else                     mc_done = 1'b1;
            state_next = IDLE;
          end else if (rollback) begin
            state_next = IDLE;
            pend_next  = 1'b0;
          end else begin
            if (pend_reg) begin
              buf_next[{cnt_reg[1:0], 3'b000} +: 8] = mem_din;
              cnt_next = cnt_reg + 3'd1;
              if (cnt_next == len_reg) begin
                if (state_reg == IFETCH) if_data_next   = buf_next;
                else                     mc_r_data_next = buf_next;
              end
            end
            pend_next = (issue_idx < {1'b0, len_reg});
          end
        end

        STORE: begin
          if (cnt_reg == len_reg) begin
            mc_done    = 1'b1;
            state_next = IDLE;
          end else if (!(is_io && io_buffer_full)) begin
            mem_wr   = 1'b1;
            cnt_next = cnt_reg + 3'd1;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      pend_reg      <= 1'b0;
      addr_reg      <= 32'd0;
      len_reg       <= 3'd0;
      wdata_reg     <= 32'd0;
      buf_reg       <= 32'd0;
      if_data_reg   <= 32'd0;
      mc_r_data_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pend_reg      <= pend_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      wdata_reg     <= wdata_next;
      buf_reg       <= buf_next;
      if_data_reg   <= if_data_next;
      mc_r_data_reg <= mc_r_data_next;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven load/store vectors with a completion scoreboard,
// plus hand sequences for arbitration, IO stall, rollback, rdy stall, reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mc_en, mc_wr;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic [31:0] mc_w_data;
  logic        mc_done;
  logic [31:0] mc_r_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int errors = 0;
  int checks = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_w_data(mc_w_data), .mc_done(mc_done), .mc_r_data(mc_r_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency, write on mem_wr
  logic [7:0] ram [logic [31:0]];
  int wr_count = 0;
  always @(posedge clk) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wr_count++;
    end
  end

  // Pulse monitors
  int if_done_cnt = 0, mc_done_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (if_done) if_done_cnt++;
    if (mc_done) mc_done_cnt++;
    if (if_done && mc_done) both_cnt++;
  end

  typedef struct {
    logic        is_if;
    logic        chk_data;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait for a done pulse; first negedge seen is the accept cycle (n=0).
  task automatic wait_done(input int exp_lat, input string name);
    int  n = 0;
    bit  found = 0;
    sb_t e;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_done || mc_done) begin
        found = 1;
        break;
      end
      n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
    end else if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: done with empty scoreboard", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_kind"}, {31'd0, if_done}, {31'd0, e.is_if});
      if (exp_lat >= 0) check({name, "_lat"}, n, exp_lat);
      if (e.chk_data)
        check({name, "_data"}, e.is_if ? if_data : mc_r_data, e.data);
      $display("txn %s: done after %0d cycles if_data=0x%08h mc_r_data=0x%08h",
               name, n, if_data, mc_r_data);
    end
  endtask

  task automatic run_mc(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                        input logic [31:0] wdata, input logic [31:0] exp, input int lat,
                        input string name);
    int w0;
    sb_t e;
    @(posedge clk); #1;
    mc_en = 1'b1; mc_wr = wr; mc_addr = addr; mc_len = len; mc_w_data = wdata;
    e.is_if = 1'b0; e.chk_data = !wr; e.data = exp;
    sb_q.push_back(e);
    w0 = wr_count;
    wait_done(lat, name);
    mc_en = 1'b0; mc_wr = 1'b0;
    @(negedge clk);
    check({name, "_one_pulse"}, {31'd0, mc_done}, 32'd0);
    if (wr) check({name, "_writes"}, wr_count - w0, {29'd0, len});
  endtask

  initial begin
    sb_t e;
    int  c0;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_addr = 32'd0;
    mc_en = 1'b0; mc_wr = 1'b0; mc_addr = 32'd0; mc_len = 3'd0; mc_w_data = 32'd0;

    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h10]  = 8'hFF; ram[32'h11]  = 8'h80;
    ram[32'h0]   = 8'h13; ram[32'h1]   = 8'h00; ram[32'h2] = 8'h00; ram[32'h3] = 8'h00;

    // {wr, addr, len, wdata, expected read, latency}
    vecs[0]  = '{1'b0, 32'h100, 3'd4, 32'h0,        32'h12345678, 6};
    vecs[1]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h000080FF, 4};
    vecs[2]  = '{1'b0, 32'h103, 3'd1, 32'h0,        32'h00000012, 3};
    vecs[3]  = '{1'b1, 32'h300, 3'd4, 32'hDEADBEEF, 32'h0,        5};
    vecs[4]  = '{1'b0, 32'h300, 3'd4, 32'h0,        32'hDEADBEEF, 6};
    vecs[5]  = '{1'b1, 32'h302, 3'd2, 32'h0000CAFE, 32'h0,        3};
    vecs[6]  = '{1'b0, 32'h300, 3'd4, 32'h0,        32'hCAFEBEEF, 6};
    vecs[7]  = '{1'b1, 32'h301, 3'd1, 32'h00000055, 32'h0,        2};
    vecs[8]  = '{1'b0, 32'h300, 3'd4, 32'h0,        32'hCAFE55EF, 6};
    vecs[9]  = '{1'b0, 32'h300, 3'd1, 32'h0,        32'h000000EF, 3};
    vecs[10] = '{1'b0, 32'h102, 3'd2, 32'h0,        32'h00001234, 4};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_mc_done", {31'd0, mc_done}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mc_r_data", mc_r_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 11; i++)
      run_mc(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, vecs[i].exp,
             vecs[i].lat, $sformatf("vec%0d", i));

    // Simultaneous fetch and SB: store first, then the fetch
    @(posedge clk); #1;
    if_en = 1'b1; if_addr = 32'h0;
    mc_en = 1'b1; mc_wr = 1'b1; mc_addr = 32'h200; mc_len = 3'd1; mc_w_data = 32'h000000AB;
    e = '{1'b0, 1'b0, 32'h0};        sb_q.push_back(e);
    e = '{1'b1, 1'b1, 32'h00000013}; sb_q.push_back(e);
    c0 = wr_count;
    wait_done(2, "simul_sb");
    mc_en = 1'b0; mc_wr = 1'b0;
    check("simul_sb_writes", wr_count - c0, 32'd1);
    check("simul_sb_ram", {24'd0, ram[32'h200]}, 32'h000000AB);
    wait_done(6, "simul_if");
    if_en = 1'b0;
    @(negedge clk);
    check("simul_if_one_pulse", {31'd0, if_done}, 32'd0);

    // IO store held off by a full FIFO for three cycles
    @(posedge clk); #1;
    io_buffer_full = 1'b1;
    mc_en = 1'b1; mc_wr = 1'b1; mc_addr = 32'h30000; mc_len = 3'd1; mc_w_data = 32'h0000005A;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("io_hold%0d_wr", k), {31'd0, mem_wr}, 32'd0);
      check($sformatf("io_hold%0d_done", k), {31'd0, mc_done}, 32'd0);
    end
    @(posedge clk); #1 io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_write_wr", {31'd0, mem_wr}, 32'd1);
    check("io_write_a", mem_a, 32'h30000);
    check("io_write_dout", {24'd0, mem_dout}, 32'h5A);
    @(negedge clk);
    check("io_done", {31'd0, mc_done}, 32'd1);
    check("io_done_wr", {31'd0, mem_wr}, 32'd0);
    mc_en = 1'b0; mc_wr = 1'b0;
    $display("txn io_store: ram[0x30000]=0x%02h", ram[32'h30000]);

    // Rollback in cycle A+3 of a fetch: no if_done
    c0 = if_done_cnt;
    @(posedge clk); #1;
    if_en = 1'b1; if_addr = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    rollback = 1'b1; if_en = 1'b0;
    @(posedge clk); #1 rollback = 1'b0;
    repeat (8) @(negedge clk);
    check("rb_fetch_no_done", if_done_cnt - c0, 32'd0);
    $display("txn rollback_fetch: if_done pulses=%0d", if_done_cnt - c0);
    // A fresh fetch proves the controller went back to IDLE
    @(posedge clk); #1;
    if_en = 1'b1; if_addr = 32'h100;
    e = '{1'b1, 1'b1, 32'h12345678}; sb_q.push_back(e);
    wait_done(6, "post_rb_fetch");
    if_en = 1'b0;

    // Rollback held through a SW: store still completes
    rollback = 1'b1;
    run_mc(1'b1, 32'h40, 3'd4, 32'h11223344, 32'h0, 5, "rb_sw");
    rollback = 1'b0;
    check("rb_sw_ram", {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]}, 32'h11223344);

    // A load is not accepted while rollback is high
    c0 = mc_done_cnt;
    @(posedge clk); #1;
    rollback = 1'b1; mc_en = 1'b1; mc_wr = 1'b0; mc_addr = 32'h100; mc_len = 3'd4;
    repeat (8) @(negedge clk);
    check("rb_load_blocked", mc_done_cnt - c0, 32'd0);
    mc_en = 1'b0; rollback = 1'b0;
    $display("txn rollback_load: mc_done pulses=%0d", mc_done_cnt - c0);

    // rdy low mid-load: result still correct, single pulse
    @(posedge clk); #1;
    mc_en = 1'b1; mc_wr = 1'b0; mc_addr = 32'h100; mc_len = 3'd4;
    e = '{1'b0, 1'b1, 32'h12345678}; sb_q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1 rdy = 1'b0;
    @(negedge clk);
    check("rdy_low_wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rdy = 1'b1;
    wait_done(-1, "rdy_stall_lw");
    mc_en = 1'b0;
    @(negedge clk);
    check("rdy_stall_one_pulse", {31'd0, mc_done}, 32'd0);

    // Reset mid-load: no done, outputs zero
    c0 = mc_done_cnt;
    @(posedge clk); #1;
    mc_en = 1'b1; mc_wr = 1'b0; mc_addr = 32'h10; mc_len = 3'd2;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; mc_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_mc_r_data", mc_r_data, 32'd0);
    check("rst_mid_if_data", if_data, 32'd0);
    check("rst_mid_mem_a", mem_a, 32'd0);
    check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mid_mem_dout", {24'd0, mem_dout}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_no_done", mc_done_cnt - c0, 32'd0);
    $display("txn reset_mid_load: mc_done pulses=%0d", mc_done_cnt - c0);

    check("never_both_done", both_cnt, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
